// File: rtl/i2s_audio_tx.sv
// I2S transmitter: one 10-bit divider produces MCLK/SCK/LRCK directly, and a
// 32-bit shift register serializes a {left,right} pair per frame with I2S one-bit delay.
module i2s_audio_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] audio_left,
    input  logic [15:0] audio_right,
    output logic        audio_mclk,
    output logic        audio_sck,
    output logic        audio_lrck,
    output logic        audio_sdin,
    output logic        sample_req
);

    logic [9:0]  r_div;
    logic [31:0] r_sh;
    logic        r_sdin;
    logic        r_sample_req;

    logic        w_bit_evt;
    logic        w_frame_load;

    // Bit events land on the SCK falling edge; the last one of the frame reloads.
    assign w_bit_evt    = (r_div[4:0] == 5'h1F);
    assign w_frame_load = (r_div == 10'h3FF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div        <= '0;
            r_sh         <= '0;
            r_sdin       <= 1'b0;
            r_sample_req <= 1'b0;
        end else if (!en) begin
            r_div        <= '0;
            r_sh         <= '0;
            r_sdin       <= 1'b0;
            r_sample_req <= 1'b0;
        end else begin
            r_div        <= r_div + 10'd1;
            r_sample_req <= w_frame_load;
            if (w_bit_evt) begin
                // Old MSB still goes out on the load, giving slot 0 the previous right LSB.
                r_sdin <= r_sh[31];
                if (w_frame_load)
                    r_sh <= {audio_left, audio_right};
                else
                    r_sh <= {r_sh[30:0], 1'b0};
            end
        end
    end

    assign audio_mclk = r_div[1];
    assign audio_sck  = r_div[4];
    assign audio_lrck = r_div[9];
    assign audio_sdin = r_sdin;
    assign sample_req = r_sample_req;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: table of sample pairs with hand-computed slot
// patterns, plus enable-drop and async-reset sequences.
module tb_i2s_audio_tx;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        audio_mclk;
    logic        audio_sck;
    logic        audio_lrck;
    logic        audio_sdin;
    logic        sample_req;

    i2s_audio_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .audio_mclk  (audio_mclk),
        .audio_sck   (audio_sck),
        .audio_lrck  (audio_lrck),
        .audio_sdin  (audio_sdin),
        .sample_req  (sample_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {prev right LSB, left[15:0], right[15:1]}; slot s is exp[31-s]
    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] exp;
    } vec_t;

    vec_t vec [10];

    int checks   = 0;
    int failures = 0;
    int clk_err  = 0;
    int sdin_err = 0;
    int req_else = 0;
    int idle_err = 0;
    int pulses   = 0;

    logic [4:0]  outs;
    logic [31:0] got;
    logic        req0;

    assign outs = {audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_req};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Runs one frame starting at the negedge where div=0; loads l/r at the frame end
    // and drives random junk on the inputs at every other time.
    task automatic frame(input logic [15:0] l, input logic [15:0] r,
                         output logic [31:0] pat, output logic rq0);
        logic psdin, psck, plrck;
        logic [9:0] d;
        pat = '0;
        rq0 = 1'b0;
        psdin = 1'b0; psck = 1'b0; plrck = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            d = 10'(i);
            if (i == 0) rq0 = sample_req;
            else if (sample_req) req_else++;
            if (d[4:0] == 5'd16) pat[31 - int'(d[9:5])] = audio_sdin;
            if ({audio_lrck, audio_sck, audio_mclk} !== {d[9], d[4], d[1]}) clk_err++;
            if (i > 0 && d[4:0] != 5'd0 && audio_sdin !== psdin) sdin_err++;
            if (i > 0 && audio_lrck != plrck && !(psck && !audio_sck)) clk_err++;
            psdin = audio_sdin; psck = audio_sck; plrck = audio_lrck;
            if (i == 1022) begin
                audio_left  = l;
                audio_right = r;
            end else if (i != 1023) begin
                audio_left  = 16'($urandom);
                audio_right = 16'($urandom);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{16'hA5C3, 16'h1234, 32'h52E1891A};
        vec[1] = '{16'h8000, 16'h7FFF, 32'h40003FFF};
        vec[2] = '{16'hFFFF, 16'h0000, 32'hFFFF8000};
        vec[3] = '{16'h8000, 16'h7FFF, 32'h40003FFF};
        vec[4] = '{16'hFFFF, 16'h0000, 32'hFFFF8000};
        vec[5] = '{16'h0001, 16'h8001, 32'h0000C000};
        vec[6] = '{16'h0000, 16'h0000, 32'h80000000};
        vec[7] = '{16'hA5C3, 16'h1234, 32'h52E1891A};
        vec[8] = '{16'h7FFF, 16'hFFFE, 32'h3FFFFFFF};
        vec[9] = '{16'h1234, 16'hA5C3, 32'h091A52E1};

        rst_n = 1'b0; en = 1'b0; audio_left = '0; audio_right = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(outs), 32'h0);

        rst_n = 1'b1;
        audio_left = 16'hFFFF; audio_right = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (outs !== 5'b0) idle_err++;
        end
        chk("idle_en_low", 32'(idle_err), 32'h0);

        // Continuous run: first frame zeros, then the table back to back.
        en = 1'b1;
        frame(vec[0].l, vec[0].r, got, req0);
        chk("first_frame_zero", got, 32'h0);
        chk("no_req_first_frame", 32'(req0), 32'h0);
        for (int k = 1; k <= 10; k++) begin
            if (k < 10) frame(vec[k].l, vec[k].r, got, req0);
            else        frame(16'h0, 16'h0, got, req0);
            pulses += int'(req0);
            chk($sformatf("frame_data_%0d", k - 1), got, vec[k - 1].exp);
        end
        chk("req_pulses_10_frames", 32'(pulses), 32'd10);

        // Enable drop at div=0x155, then restart.
        repeat (12'h155) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_outs", 32'(outs), 32'h0);
        idle_err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (outs !== 5'b0) idle_err++;
        end
        chk("en_low_hold", 32'(idle_err), 32'h0);
        en = 1'b1;
        frame(vec[0].l, vec[0].r, got, req0);
        chk("en_restart_zero_frame", got, 32'h0);
        chk("en_restart_no_req", 32'(req0), 32'h0);
        frame(16'h0, 16'h0, got, req0);
        chk("en_restart_req_1024", 32'(req0), 32'h1);
        chk("en_restart_data", got, vec[0].exp);

        // Async reset between clock edges at div=0x2A0 (lrck high).
        repeat (12'h2A0) @(negedge clk);
        chk("pre_reset_lrck", 32'(audio_lrck), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", 32'(outs), 32'h0);
        repeat (3) @(negedge clk);
        chk("reset_hold_outs", 32'(outs), 32'h0);
        rst_n = 1'b1;
        frame(vec[0].l, vec[0].r, got, req0);
        chk("rst_restart_zero_frame", got, 32'h0);
        chk("rst_restart_no_req", 32'(req0), 32'h0);
        frame(16'h0, 16'h0, got, req0);
        chk("rst_restart_req_1024", 32'(req0), 32'h1);
        chk("rst_restart_data", got, vec[0].exp);

        chk("clock_outputs", 32'(clk_err), 32'h0);
        chk("sdin_stable_between_events", 32'(sdin_err), 32'h0);
        chk("req_only_at_div0", 32'(req_else), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_audio_tx.md
I2S_AUDIO_TX -- requirements
Module: i2s_audio_tx

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  serializer enable; low holds the block idle
- audio_left  input  16  left sample, two's complement, sampled only at frame load
- audio_right  input  16  right sample, two's complement, sampled only at frame load
- audio_mclk  output  1  DAC master clock, clk/4 (25 MHz)
- audio_sck  output  1  serial bit clock, clk/32 (3.125 MHz)
- audio_lrck  output  1  word select, clk/1024 (97.656 kHz); low = left, high = right
- audio_sdin  output  1  serial data, I2S format, MSB first
- sample_req  output  1  one-cycle pulse marking the cycle after a new sample pair was captured

Function
REQ-002 The block SHALL keep one 10-bit free-running divider register div, incrementing by 1 per clk while en=1 and wrapping 0x3FF->0x000.
REQ-003 The outputs SHALL be driven directly from div bits, with no extra logic: audio_mclk=div[1], audio_sck=div[4], audio_lrck=div[9].
REQ-004 A bit event SHALL occur on every clk edge where div[4:0]=31; this coincides with the audio_sck falling edge.
REQ-005 The block SHALL keep a 32-bit shift register sh. On every bit event, audio_sdin<=sh[31] and sh<=sh<<1, except as stated in REQ-006.
REQ-006 On the bit event where div=0x3FF (frame load), the block SHALL capture both channels: sh<={audio_left,audio_right} and audio_sdin<=old sh[31].
REQ-007 The frame load SHALL give the I2S one-bit delay after each lrck transition:
- bit slot 0 (div[9:5]=0) carries the previous right LSB
- slots 1..16 carry left[15:0]
- slots 17..31 carry right[15:1]
REQ-008 audio_sdin SHALL change only on bit events and SHALL hold its value between them.
REQ-009 sample_req SHALL be a registered output, high for exactly one clk cycle, in the cycle after each frame load (div=0x000 with en=1).
REQ-010 Upstream SHALL hold audio_left/audio_right stable in the cycle where div=0x3FF. Values at any other time SHALL have no effect.
REQ-011 While en=0, the block SHALL force the following each cycle:
- div=0, sh=0, audio_sdin=0, sample_req=0
- as a result, audio_mclk, audio_sck and audio_lrck are all 0
REQ-012 Dropping en mid-frame SHALL abort the frame at the next clk edge. Partially sent data is discarded and not resumed.
REQ-013 When en rises, div SHALL start counting from 0 on the next edge. The first frame after en rises transmits all zeros; the first capture happens 1024 cycles after en rises.
REQ-014 Latency from sample capture (div=0x3FF edge) to left MSB on audio_sdin SHALL be 32 clk cycles (edge where div 0x01F->0x020).
REQ-015 Timing ratios SHALL be fixed, with no runtime configuration:
- MCLK/LRCK = 256
- SCK/LRCK = 64 half-periods (32 SCK cycles per frame, 16 bits per channel)

Reset
REQ-016 rst_n low SHALL asynchronously clear div, sh, audio_sdin and sample_req to 0, which makes all outputs 0.
REQ-017 After rst_n deasserts, the block SHALL behave as in REQ-013 if en=1, or stay idle if en=0.
REQ-018 A reset asserted mid-frame SHALL take effect immediately, with no completion of the current word.

Verification
REQ-019 Clock check: en=1 steady for 4096 cycles -> audio_mclk period 4, audio_sck period 32, audio_lrck period 1024, each 50% duty; lrck edges align with sck falling edges.
REQ-020 Data check: L=0xA5C3, R=0x1234 held constant -> sdin slots 1..16 read 1010010111000011 and slots 17..31 plus next slot 0 read 0001001000110100, sampled at sck rising edges.
REQ-021 Boundary check: alternate samples 0x8000/0x7FFF and 0xFFFF/0x0000 per frame -> each frame's slot 0 carries the previous frame's right LSB; no bit is lost or duplicated across the frame wrap.
REQ-022 Handshake check: count sample_req pulses over 10 frames -> exactly 10 pulses, each one cycle wide at div=0. Changing inputs outside div=0x3FF has no effect on sdin.
REQ-023 Enable check: deassert en at div=0x155 -> all outputs 0 on the next edge. Reassert en -> the first frame is all zeros, sample_req first fires 1024 cycles later, and the second frame carries the captured data.
REQ-024 Reset check: assert rst_n low asynchronously mid-bit (between clk edges) -> outputs 0 immediately. Release with en=1 -> same sequence as REQ-023.
